// File: rtl/bp_be_pkg.sv
// Issue-queue types: per-entry predecode struct plus the parameterised head-status struct and width.
`ifndef BP_BE_PKG_DEFINES
`define BP_BE_PKG_DEFINES

`define DECLARE_BP_BE_ISD_STATUS_S(vaddr_width_mp, meta_width_mp) \
    typedef struct packed {                                       \
        logic                            isd_v;                   \
        logic [vaddr_width_mp-1:0]       pc;                      \
        logic [meta_width_mp-1:0]        meta;                    \
        logic [31:0]                     instr;                   \
        bp_be_pkg::bp_be_issue_predecode_s pd;                    \
    } bp_be_isd_status_s

`define BP_BE_ISD_STATUS_WIDTH(vaddr_width_mp, meta_width_mp) \
    (1 + (vaddr_width_mp) + (meta_width_mp) + 32 + $bits(bp_be_pkg::bp_be_issue_predecode_s))

`endif

package bp_be_pkg;

    typedef struct packed {
        logic       fence_v;
        logic       csr_v;
        logic       mem_v;
        logic       long_v;
        logic       irs1_v;
        logic       irs2_v;
        logic       frs1_v;
        logic       frs2_v;
        logic       frs3_v;
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [4:0] rs3_addr;
    } bp_be_issue_predecode_s;

endpackage

// File: rtl/bp_common_rv64_pkg.sv
// RV64 major opcodes and the funct fields the back end needs during predecode.
package bp_common_rv64_pkg;

    typedef enum logic [6:0] {
        RV64_LOAD      = 7'b0000011,
        RV64_LOAD_FP   = 7'b0000111,
        RV64_MISC_MEM  = 7'b0001111,
        RV64_OP_IMM    = 7'b0010011,
        RV64_AUIPC     = 7'b0010111,
        RV64_OP_IMM_32 = 7'b0011011,
        RV64_STORE     = 7'b0100011,
        RV64_STORE_FP  = 7'b0100111,
        RV64_AMO       = 7'b0101111,
        RV64_OP        = 7'b0110011,
        RV64_LUI       = 7'b0110111,
        RV64_OP_32     = 7'b0111011,
        RV64_FMADD     = 7'b1000011,
        RV64_FMSUB     = 7'b1000111,
        RV64_FNMSUB    = 7'b1001011,
        RV64_FNMADD    = 7'b1001111,
        RV64_OP_FP     = 7'b1010011,
        RV64_BRANCH    = 7'b1100011,
        RV64_JALR      = 7'b1100111,
        RV64_JAL       = 7'b1101111,
        RV64_SYSTEM    = 7'b1110011
    } rv64_opcode_e;

    // OP-FP funct5 values that change operand sourcing or latency
    localparam logic [4:0] rv64_f5_fdiv    = 5'b00011;
    localparam logic [4:0] rv64_f5_fsqrt   = 5'b01011;
    localparam logic [4:0] rv64_f5_fcvt_ff = 5'b01000;
    localparam logic [4:0] rv64_f5_fcvt_xf = 5'b11000;
    localparam logic [4:0] rv64_f5_fmv_xf  = 5'b11100;
    localparam logic [4:0] rv64_f5_fcvt_fx = 5'b11010;
    localparam logic [4:0] rv64_f5_fmv_fx  = 5'b11110;

    localparam logic [6:0] rv64_f7_muldiv     = 7'b0000001;
    localparam logic [6:0] rv64_f7_sfence_vma = 7'b0001001;

endpackage

// File: rtl/bp_be_instr_predecode.sv
// Combinational RV64 predecode: operand-valid flags and pipe-class hints for one raw instruction.
module bp_be_instr_predecode
    import bp_common_rv64_pkg::*;
    import bp_be_pkg::*;
(
    input  logic [31:0]            instr_i,
    output bp_be_issue_predecode_s pd_o
);

    rv64_opcode_e opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [4:0]   funct5;
    logic         fp_int_src;
    logic         fp_single_op;
    logic         unused_rd;

    assign opcode    = rv64_opcode_e'(instr_i[6:0]);
    assign funct3    = instr_i[14:12];
    assign funct7    = instr_i[31:25];
    assign funct5    = instr_i[31:27];
    // rd never affects issue decisions
    assign unused_rd = ^instr_i[11:7];

    assign fp_int_src   = (funct5 == rv64_f5_fcvt_fx) || (funct5 == rv64_f5_fmv_fx);
    assign fp_single_op = (funct5 == rv64_f5_fsqrt)   || (funct5 == rv64_f5_fcvt_ff)
                       || (funct5 == rv64_f5_fcvt_xf) || (funct5 == rv64_f5_fmv_xf);

    always_comb begin
        pd_o          = '0;
        pd_o.rs1_addr = instr_i[19:15];
        pd_o.rs2_addr = instr_i[24:20];
        pd_o.rs3_addr = instr_i[31:27];

        case (opcode)
            RV64_LOAD, RV64_LOAD_FP: begin
                pd_o.mem_v  = 1'b1;
                pd_o.irs1_v = 1'b1;
            end
            RV64_STORE, RV64_AMO: begin
                pd_o.mem_v  = 1'b1;
                pd_o.irs1_v = 1'b1;
                pd_o.irs2_v = 1'b1;
            end
            RV64_STORE_FP: begin
                pd_o.mem_v  = 1'b1;
                pd_o.irs1_v = 1'b1;
                pd_o.frs2_v = 1'b1;
            end
            RV64_MISC_MEM: pd_o.fence_v = 1'b1;
            RV64_OP_IMM, RV64_OP_IMM_32, RV64_JALR: pd_o.irs1_v = 1'b1;
            RV64_OP, RV64_OP_32: begin
                pd_o.irs1_v = 1'b1;
                pd_o.irs2_v = 1'b1;
                pd_o.long_v = (funct7 == rv64_f7_muldiv) && funct3[2];
            end
            RV64_BRANCH: begin
                pd_o.irs1_v = 1'b1;
                pd_o.irs2_v = 1'b1;
            end
            RV64_SYSTEM: begin
                // csrrw/csrrs/csrrc read rs1; the immediate forms have funct3[2] set
                pd_o.csr_v   = (funct3 != 3'b000);
                pd_o.irs1_v  = (funct3 != 3'b000) && !funct3[2];
                pd_o.fence_v = (funct7 == rv64_f7_sfence_vma);
            end
            RV64_OP_FP: begin
                pd_o.irs1_v = fp_int_src;
                pd_o.frs1_v = !fp_int_src;
                pd_o.frs2_v = !fp_int_src && !fp_single_op;
                pd_o.long_v = (funct5 == rv64_f5_fdiv) || (funct5 == rv64_f5_fsqrt);
            end
            RV64_FMADD, RV64_FMSUB, RV64_FNMSUB, RV64_FNMADD: begin
                pd_o.frs1_v = 1'b1;
                pd_o.frs2_v = 1'b1;
                pd_o.frs3_v = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bp_be_issue_queue.sv
// Circular issue buffer between the FE queue and the checker; predecodes at enqueue, head is registered state.
module bp_be_issue_queue
    import bp_be_pkg::*;
#(
    parameter  int vaddr_width_p               = 39,
    parameter  int branch_metadata_fwd_width_p = 36,
    // must be a power of two, >= 2, so pointer wrap is a plain binary overflow
    parameter  int els_p                       = 8,
    localparam int isd_status_width_lp         =
        `BP_BE_ISD_STATUS_WIDTH(vaddr_width_p, branch_metadata_fwd_width_p)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   fe_v_i,
    output logic                                   fe_ready_o,
    input  logic [vaddr_width_p-1:0]               fe_pc_i,
    input  logic [31:0]                            fe_instr_i,
    input  logic [branch_metadata_fwd_width_p-1:0] fe_meta_i,
    input  logic                                   poison_i,
    input  logic                                   chk_dispatch_v_i,
    output logic [isd_status_width_lp-1:0]         isd_status_o,
    output logic                                   empty_o
);

    `DECLARE_BP_BE_ISD_STATUS_S(vaddr_width_p, branch_metadata_fwd_width_p);

    localparam int idx_w_lp = $clog2(els_p);
    localparam int ptr_w_lp = idx_w_lp + 1;

    logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [idx_w_lp-1:0] rd_idx, wr_idx;

    logic [vaddr_width_p-1:0]               pc_mem_q    [els_p];
    logic [vaddr_width_p-1:0]               pc_mem_d    [els_p];
    logic [branch_metadata_fwd_width_p-1:0] meta_mem_q  [els_p];
    logic [branch_metadata_fwd_width_p-1:0] meta_mem_d  [els_p];
    logic [31:0]                            instr_mem_q [els_p];
    logic [31:0]                            instr_mem_d [els_p];
    bp_be_issue_predecode_s                 pd_mem_q    [els_p];
    bp_be_issue_predecode_s                 pd_mem_d    [els_p];

    bp_be_issue_predecode_s fe_pd;
    bp_be_isd_status_s      isd_status;

    logic empty, full, enq, deq;

    bp_be_instr_predecode u_predecode (
        .instr_i (fe_instr_i),
        .pd_o    (fe_pd)
    );

    assign rd_idx = rd_ptr_q[idx_w_lp-1:0];
    assign wr_idx = wr_ptr_q[idx_w_lp-1:0];
    assign empty  = (rd_ptr_q == wr_ptr_q);
    assign full   = (rd_ptr_q[idx_w_lp-1:0] == wr_ptr_q[idx_w_lp-1:0])
                 && (rd_ptr_q[ptr_w_lp-1]  != wr_ptr_q[ptr_w_lp-1]);

    // Ready is a pure function of stored state; a same-cycle dispatch cannot free a slot for the FE.
    assign fe_ready_o = !full;
    assign empty_o    = empty;
    assign enq        = fe_v_i && !full && !poison_i;
    assign deq        = chk_dispatch_v_i && !empty && !poison_i;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        pc_mem_d    = pc_mem_q;
        meta_mem_d  = meta_mem_q;
        instr_mem_d = instr_mem_q;
        pd_mem_d    = pd_mem_q;

        if (poison_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (enq) begin
                pc_mem_d[wr_idx]    = fe_pc_i;
                meta_mem_d[wr_idx]  = fe_meta_i;
                instr_mem_d[wr_idx] = fe_instr_i;
                pd_mem_d[wr_idx]    = fe_pd;
                wr_ptr_d            = wr_ptr_q + ptr_w_lp'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Payload needs no reset: it is only visible through a valid pointer range.
    always_ff @(posedge clk_i) begin
        pc_mem_q    <= pc_mem_d;
        meta_mem_q  <= meta_mem_d;
        instr_mem_q <= instr_mem_d;
        pd_mem_q    <= pd_mem_d;
    end

    always_comb begin
        isd_status = '0;
        if (!empty) begin
            isd_status.isd_v = 1'b1;
            isd_status.pc    = pc_mem_q[rd_idx];
            isd_status.meta  = meta_mem_q[rd_idx];
            isd_status.instr = instr_mem_q[rd_idx];
            isd_status.pd    = pd_mem_q[rd_idx];
        end
    end

    assign isd_status_o = isd_status;

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Scoreboard bench for bp_be_issue_queue: directed scenarios plus random traffic against a FIFO model.
module tb_bp_be_issue_queue;

    localparam int VW  = 39;
    localparam int MW  = 36;
    localparam int ELS = 8;
    localparam int SW  = 1 + VW + MW + 32 + 24;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          fe_v_i = 1'b0;
    logic          fe_ready_o;
    logic [VW-1:0] fe_pc_i = '0;
    logic [31:0]   fe_instr_i = '0;
    logic [MW-1:0] fe_meta_i = '0;
    logic          poison_i = 1'b0;
    logic          chk_dispatch_v_i = 1'b0;
    logic [SW-1:0] isd_status_o;
    logic          empty_o;

    bp_be_issue_queue #(
        .vaddr_width_p               (VW),
        .branch_metadata_fwd_width_p (MW),
        .els_p                       (ELS)
    ) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .fe_v_i           (fe_v_i),
        .fe_ready_o       (fe_ready_o),
        .fe_pc_i          (fe_pc_i),
        .fe_instr_i       (fe_instr_i),
        .fe_meta_i        (fe_meta_i),
        .poison_i         (poison_i),
        .chk_dispatch_v_i (chk_dispatch_v_i),
        .isd_status_o     (isd_status_o),
        .empty_o          (empty_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [VW-1:0] pc;
        logic [MW-1:0] meta;
        logic [31:0]   instr;
    } ent_t;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_count = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference predecode written directly from the opcode class rules.
    function automatic logic [23:0] ref_pd(input logic [31:0] i);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] f5;
        bit fma, fp, int_src, single, fence, csr, mem, lng, irs1, irs2, frs1, frs2, frs3;
        op  = i[6:0];
        f3  = i[14:12];
        f7  = i[31:25];
        f5  = i[31:27];
        fp      = (op == 7'b1010011);
        fma     = op inside {7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111};
        int_src = fp && (f5 inside {5'b11010, 5'b11110});
        single  = fp && (f5 inside {5'b01011, 5'b01000, 5'b11000, 5'b11100});
        fence = (op == 7'b0001111) || (op == 7'b1110011 && f7 == 7'b0001001);
        csr   = (op == 7'b1110011) && (f3 != 3'd0);
        mem   = op inside {7'b0000011, 7'b0100011, 7'b0101111, 7'b0000111, 7'b0100111};
        lng   = ((op inside {7'b0110011, 7'b0111011}) && f7 == 7'b0000001 && f3[2])
             || (fp && (f5 inside {5'b00011, 5'b01011}));
        irs1  = (op inside {7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011, 7'b0000011,
                            7'b0100011, 7'b1100011, 7'b1100111, 7'b0101111, 7'b0000111,
                            7'b0100111})
             || (csr && !f3[2]) || int_src;
        irs2  = op inside {7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011, 7'b0101111};
        frs1  = (fp && !int_src) || fma;
        frs2  = (frs1 && !single) || (op == 7'b0100111);
        frs3  = fma;
        return {fence, csr, mem, lng, irs1, irs2, frs1, frs2, frs3, i[19:15], i[24:20], i[31:27]};
    endfunction

    function automatic logic [SW-1:0] exp_status(input ent_t e);
        return {1'b1, e.pc, e.meta, e.instr, ref_pd(e.instr)};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [21];
        logic [4:0] f5s [9];
        logic [31:0] ins;
        ops = '{7'b0000011, 7'b0000111, 7'b0001111, 7'b0010011, 7'b0010111, 7'b0011011,
                7'b0100011, 7'b0100111, 7'b0101111, 7'b0110011, 7'b0110111, 7'b0111011,
                7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111, 7'b1010011, 7'b1100011,
                7'b1100111, 7'b1101111, 7'b1110011};
        f5s = '{5'b00000, 5'b00011, 5'b01011, 5'b01000, 5'b11000, 5'b11100,
                5'b11010, 5'b11110, 5'b10100};
        ins      = $urandom;
        ins[6:0] = ops[$urandom_range(20)];
        if (ins[6:0] == 7'b1010011 && $urandom_range(1) == 1) ins[31:27] = f5s[$urandom_range(8)];
        if ((ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0111011) && $urandom_range(1) == 1)
            ins[31:25] = 7'b0000001;
        if (ins[6:0] == 7'b1110011) begin
            if ($urandom_range(2) == 0) ins[31:25] = 7'b0001001;
            if ($urandom_range(2) == 0) ins[14:12] = 3'b000;
        end
        return ins;
    endfunction

    // One cycle of stimulus; the model records the pre-edge occupancy and pushes accepted entries.
    task automatic drive(input logic fv, input logic [VW-1:0] pc, input logic [31:0] ins,
                         input logic [MW-1:0] meta, input logic pz, input logic dv);
        ent_t e;
        @(posedge clk_i);
        #1;
        fe_v_i           = fv;
        fe_pc_i          = pc;
        fe_instr_i       = ins;
        fe_meta_i        = meta;
        poison_i         = pz;
        chk_dispatch_v_i = dv;
        exp_count        = sb.size();
        if (pz) begin
            sb.delete();
        end else if (fv && exp_count < ELS) begin
            e.pc = pc; e.meta = meta; e.instr = ins;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input logic dv);
        drive(1'b0, '0, 32'h0, '0, 1'b0, dv);
    endtask

    always @(negedge clk_i) begin
        if (mon_en) begin
            check("fe_ready", SW'(fe_ready_o), SW'(exp_count < ELS));
            check("empty", SW'(empty_o), SW'(exp_count == 0));
            if (exp_count == 0) begin
                check("idle_status_zero", isd_status_o, '0);
            end else if (!poison_i) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL head_underflow: got nothing expected an entry");
                end else begin
                    check(chk_dispatch_v_i ? "dispatch_head" : "head", isd_status_o, exp_status(sb[0]));
                    if (chk_dispatch_v_i) void'(sb.pop_front());
                end
            end
        end
    end

    logic [31:0] fmadd_i, div_i, csrrwi_i;

    initial begin
        fmadd_i  = {5'd4, 2'b01, 5'd3, 5'd2, 3'b111, 5'd1, 7'b1000011};
        div_i    = {7'b0000001, 5'd7, 5'd6, 3'b100, 5'd5, 7'b0110011};
        csrrwi_i = {12'h300, 5'd5, 3'b101, 5'd1, 7'b1110011};

        #12;
        check("reset_status", isd_status_o, '0);
        check("reset_empty", SW'(empty_o), SW'(1));
        check("reset_ready", SW'(fe_ready_o), SW'(1));
        #11;
        reset_n_i = 1'b1;
        mon_en    = 1'b1;

        // single enqueue, dispatch, empty again
        drive(1'b1, 39'h80000000, 32'h00100093, 36'h123, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // fill to 8, offer a 9th, drain in order
        for (int i = 0; i < 9; i++) drive(1'b1, VW'(32'h1000 + 4 * i), rand_instr(), MW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) idle(1'b1);
        idle(1'b0);

        // full queue: simultaneous dispatch and offer dequeues only
        for (int i = 0; i < 8; i++) drive(1'b1, VW'(32'h2000 + 4 * i), rand_instr(), MW'(i), 1'b0, 1'b0);
        drive(1'b1, 39'h3000, 32'h00000013, 36'h0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) idle(1'b1);
        idle(1'b0);

        // poison with 5 entries and a concurrent enqueue
        for (int i = 0; i < 5; i++) drive(1'b1, VW'(32'h4000 + 4 * i), rand_instr(), MW'(i), 1'b0, 1'b0);
        drive(1'b1, 39'h5000, 32'h00000013, 36'h5, 1'b1, 1'b1);
        idle(1'b0);
        idle(1'b0);

        // predecode spot checks against hand-derived flags
        drive(1'b1, 39'h6000, fmadd_i, 36'h1, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk_i);
        check("pd_fmadd", SW'(isd_status_o[23:0]), SW'({9'b000000111, 5'd2, 5'd3, 5'd4}));
        idle(1'b1);
        drive(1'b1, 39'h6004, div_i, 36'h2, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk_i);
        check("pd_div", SW'(isd_status_o[23:0]), SW'({9'b000111000, 5'd6, 5'd7, 5'd0}));
        idle(1'b1);
        drive(1'b1, 39'h6008, csrrwi_i, 36'h3, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk_i);
        check("pd_csrrwi", SW'(isd_status_o[23:0]), SW'({9'b010000000, 5'd5, 5'd0, 5'd6}));
        idle(1'b1);
        idle(1'b0);

        // random traffic
        for (int c = 0; c < 10000; c++) begin
            drive($urandom_range(99) < 60, VW'({$urandom, $urandom}), rand_instr(),
                  MW'({$urandom, $urandom}), $urandom_range(99) < 2, $urandom_range(99) < 50);
        end
        idle(1'b0);

        // asynchronous reset mid-operation
        for (int i = 0; i < 4; i++) drive(1'b1, VW'(32'h7000 + 4 * i), rand_instr(), MW'(i), 1'b0, 1'b0);
        @(posedge clk_i);
        #2;
        mon_en    = 1'b0;
        fe_v_i    = 1'b0;
        reset_n_i = 1'b0;
        #1;
        check("async_rst_status", isd_status_o, '0);
        check("async_rst_empty", SW'(empty_o), SW'(1));
        check("async_rst_ready", SW'(fe_ready_o), SW'(1));
        sb.delete();
        exp_count = 0;
        #4;
        reset_n_i = 1'b1;
        mon_en    = 1'b1;
        idle(1'b1);
        idle(1'b0);
        @(negedge clk_i);

        if (sb.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL leftover_entries: got %0d expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
